// File: rtl/i2c_apb_arb.sv
// i2c_apb_arb: two-requester round-robin arbiter and sequencer in front of
// the i2c_core APB slave port. Each grant runs one fixed-length SETUP/ACCESS
// transfer (the slave has no pready) and ends with a one-cycle done pulse to
// the requester that owned the bus.
// Optional feature: define I2C_ARB_LOCK_EN to let the owner keep the bus for
// back-to-back transfers while it holds its lock input high. Without the
// macro the lock inputs are ignored and arbitration is pure round-robin.
module i2c_apb_arb #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          pclk,
  input  logic          prst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          lock0,
  input  logic          lock1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          owner,
  output logic          busy,
  output logic          psel,
  output logic          penable,
  output logic          pwrite,
  output logic [AW-1:0] paddr,
  output logic [DW-1:0] pwdata,
  input  logic [DW-1:0] prdata
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t state_q, state_d;
  logic   ptr_q, ptr_d;     // requester preferred when both ask
  logic   hold_q, hold_d;   // owner keeps the bus across transfers
  logic   owner_d;
  logic   grant;
  logic   elig0, elig1;
  logic   lock_owner;

`ifdef I2C_ARB_LOCK_EN
  assign lock_owner = owner ? lock1 : lock0;
`else
  // Lock inputs stay on the port list so instantiations do not change.
  logic unused_lock;
  assign unused_lock = lock0 ^ lock1;
  assign lock_owner  = 1'b0;
`endif

  // Next state, grant decision, pointer and lock-hold update.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    owner_d = owner;
    elig0   = req0;
    elig1   = req1;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (hold_q) begin
          if (lock_owner) begin
            // Only the locking owner may be granted; the other one waits.
            elig0 = req0 & ~owner;
            elig1 = req1 &  owner;
          end else begin
            hold_d = 1'b0;
          end
        end
        if (elig0 | elig1) begin
          grant   = 1'b1;
          owner_d = (elig0 & elig1) ? ptr_q : elig1;
          state_d = SETUP;
        end
      end
      SETUP:  state_d = ACCESS;
      ACCESS: state_d = DONE;
      DONE: begin
        state_d = IDLE;
        hold_d  = lock_owner;
        if (!lock_owner) ptr_d = ~owner;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge pclk) begin
    if (prst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Registered outputs and arbitration bookkeeping, all derived from the
  // state being entered so every output is a flop.
  always_ff @(posedge pclk) begin
    // NOTE: non-blocking assignments here, so every flop samples the values
    // from before this edge regardless of statement order.
    if (prst) begin
      ptr_q   <= 1'b0;
      hold_q  <= 1'b0;
      owner   <= 1'b0;
      busy    <= 1'b0;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      owner   <= owner_d;
      busy    <= (state_d != IDLE);
      psel    <= (state_d == SETUP) || (state_d == ACCESS);
      penable <= (state_d == ACCESS);
      done0   <= (state_d == DONE) && !owner_d;
      done1   <= (state_d == DONE) &&  owner_d;
      // APB fields change only on a grant and hold until the next one.
      if (grant) begin
        pwrite <= owner_d ? we1    : we0;
        paddr  <= owner_d ? addr1  : addr0;
        pwdata <= owner_d ? wdata1 : wdata0;
      end
      // Read data is captured at the end of ACCESS; writes leave it alone.
      if (state_q == ACCESS && !pwrite) begin
        if (owner) rdata1 <= prdata;
        else       rdata0 <= prdata;
      end
    end
  end

endmodule
